// File: rtl/mips8_pkg.sv
// mips8_pkg: shared widths and register-index names for the 8-bit MIPS datapath
package mips8_pkg;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;
    typedef enum logic [ADDR_W-1:0] {R0, R1, R2, R3, R4, R5, R6, R7} reg_idx_e;
endpackage

// File: rtl/wr_decode.sv
// wr_decode: write-address to one-hot register enable, gated by we, bit 0 never set
module wr_decode #(
    parameter int ADDR_W = mips8_pkg::ADDR_W
) (
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    output logic [2**ADDR_W-1:0] en
);
    always_comb begin
        en        = '0;
        en[waddr] = we;
        en[0]     = 1'b0;
    end
endmodule

// File: rtl/reg_file_wr.sv
// reg_file_wr: 8x8 register file, r0 hardwired to zero, same-cycle write-to-read bypass
module reg_file_wr #(
    parameter int DATA_W = mips8_pkg::DATA_W,
    parameter int ADDR_W = mips8_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1
);
    import mips8_pkg::*;
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]  en;
    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic [DATA_W-1:0] view [DEPTH];
    logic [ADDR_W-1:0] ra   [2];
    logic [DATA_W-1:0] rd   [2];

    wr_decode #(.ADDR_W(ADDR_W)) u_dec (.we(we), .waddr(waddr), .en(en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) if (en[i]) regs[i] <= wdata;
        end
    end

    // view[0] stands in for the missing r0 storage so reads stay a plain mux
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < DEPTH; i++) view[i] = regs[i];
    end

    assign ra[0] = raddr0;
    assign ra[1] = raddr1;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        assign rd[p] = (ra[p] != REG_ZERO && we && waddr == ra[p]) ? wdata : view[ra[p]];
    end

    assign rdata0 = rd[0];
    assign rdata1 = rd[1];
endmodule

// File: tb/tb_reg_file_wr.sv
// tb_reg_file_wr: directed and randomized checks against an array model of the register file
`timescale 1ns/100ps
module tb_reg_file_wr;
    logic       clk = 0;
    logic       rst_n = 1;
    logic       we = 0;
    logic [2:0] waddr = 0, raddr0 = 0, raddr1 = 0;
    logic [7:0] wdata = 0;
    logic [7:0] rdata0, rdata1;
    logic [7:0] m [8];
    logic       chk_en = 0;
    int         errors = 0, total = 0;

    reg_file_wr dut (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
                     .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1));

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m[i] <= 8'h00;
        end else if (we && waddr != 0) begin
            m[waddr] <= wdata;
        end
    end

    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        if (a == 0) return 8'h00;
        if (we && waddr == a) return wdata;
        return m[a];
    endfunction

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rd0", rdata0, exp_rd(raddr0));
            check("model_rd1", rdata1, exp_rd(raddr1));
        end
    end

    initial begin
        #2 rst_n = 0;
        #10;
        for (int a = 0; a < 8; a++) begin
            raddr0 = 3'(a);
            raddr1 = 3'(7 - a);
            #0.5;
            check("reset_rd0", rdata0, 8'h00);
            check("reset_rd1", rdata1, 8'h00);
        end
        chk_en = 1;
        rst_n = 1;
        step;
        for (int i = 1; i < 8; i++) begin
            we = 1; waddr = 3'(i); wdata = 8'hFF;
            step;
        end
        we = 0; raddr0 = 7; raddr1 = 1;
        #1;
        check("fill_r7", rdata0, 8'hFF);
        check("fill_r1", rdata1, 8'hFF);
        step;
        rst_n = 0;
        #0.5;
        for (int a = 1; a < 8; a++) begin
            raddr0 = 3'(a);
            raddr1 = 3'(8 - a);
            #0.5;
            check("async_rst_rd0", rdata0, 8'h00);
            check("async_rst_rd1", rdata1, 8'h00);
        end
        rst_n = 1;
        we = 1; waddr = 3; wdata = 8'hA5; raddr0 = 0; raddr1 = 0;
        step;
        we = 0; raddr0 = 3; raddr1 = 4;
        #1;
        check("basic_r3", rdata0, 8'hA5);
        check("basic_r4", rdata1, 8'h00);
        we = 1; waddr = 0; wdata = 8'h5A; raddr0 = 0; raddr1 = 0;
        #1;
        check("zero_pre", rdata0, 8'h00);
        check("zero_pre1", rdata1, 8'h00);
        step;
        we = 0;
        #1;
        check("zero_post", rdata0, 8'h00);
        we = 1; waddr = 2; wdata = 8'h11;
        step;
        we = 1; waddr = 2; wdata = 8'h22; raddr0 = 2; raddr1 = 2;
        #1;
        check("bypass_rd0", rdata0, 8'h22);
        check("bypass_rd1", rdata1, 8'h22);
        step;
        we = 0;
        #1;
        check("bypass_stored0", rdata0, 8'h22);
        check("bypass_stored1", rdata1, 8'h22);
        we = 1; waddr = 5; wdata = 8'h33;
        step;
        we = 0; waddr = 5; wdata = 8'h77; raddr1 = 5;
        #1;
        check("hold_nobypass", rdata1, 8'h33);
        repeat (3) step;
        check("hold_r5", rdata1, 8'h33);
        we = 1; waddr = 6; wdata = 8'h99; raddr0 = 6;
        #1 rst_n = 0;
        step;
        rst_n = 1; we = 0;
        #1;
        check("rst_beats_write", rdata0, 8'h00);
        for (int c = 0; c < 3000; c++) begin
            step;
            rst_n = ($urandom_range(0, 99) != 0);
            we = $urandom_range(0, 2) != 0;
            waddr = 3'($urandom);
            wdata = 8'($urandom);
            raddr0 = $urandom_range(0, 3) == 0 ? waddr : 3'($urandom);
            raddr1 = $urandom_range(0, 3) == 0 ? waddr : 3'($urandom);
        end
        step;
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end
endmodule
